// File: rtl/enc_pwm_mixer.sv
// Multi-channel quadrature-detent mixer: debounced encoder inputs adjust per-channel
// values that drive period-aligned PWM outputs, plus a registered debug readback.
module enc_pwm_mixer #(
  parameter int NCH     = 3,
  parameter int WIDTH   = 8,
  parameter int DEB_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [NCH-1:0]   enc_a,
  input  logic [NCH-1:0]   enc_b,
  input  logic             sat_mode,
  input  logic             step_x4,
  input  logic [1:0]       dbg_sel,
  output logic [NCH-1:0]   pwm_out,
  output logic [WIDTH-1:0] dbg_val
);

  localparam int              PW         = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DEB_DIV - 1);
  localparam logic [WIDTH-1:0] VMAX      = '1;

  logic [NCH-1:0]   a_meta_q, a_meta_d, a_sync_q, a_sync_d;
  logic [NCH-1:0]   b_meta_q, b_meta_d, b_sync_q, b_sync_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             strobe;
  logic [1:0]       prime_q, prime_d;
  logic [NCH-1:0]   a_samp_q, a_samp_d, b_samp_q, b_samp_d;
  logic [NCH-1:0]   a_deb_q, a_deb_d, b_deb_q, b_deb_d;
  logic [NCH-1:0]   a_agree, b_agree;
  logic [NCH-1:0]   evt_inc_q, evt_inc_d, evt_dec_q, evt_dec_d;
  logic [WIDTH-1:0] value_q [NCH];
  logic [WIDTH-1:0] value_d [NCH];
  logic [WIDTH-1:0] duty_q  [NCH];
  logic [WIDTH-1:0] duty_d  [NCH];
  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NCH-1:0]   pwm_q, pwm_d;
  logic [WIDTH-1:0] dbg_q, dbg_d;

  function automatic logic [WIDTH-1:0] next_value(input logic [WIDTH-1:0] cur,
                                                  input logic inc,
                                                  input logic sat,
                                                  input logic x4);
    logic [WIDTH:0] step;
    logic [WIDTH:0] sum;
    step = x4 ? (WIDTH+1)'(4) : (WIDTH+1)'(1);
    sum  = {1'b0, cur} + step;
    if (inc) next_value = (sat && sum[WIDTH]) ? VMAX : sum[WIDTH-1:0];
    else     next_value = (sat && ({1'b0, cur} < step)) ? '0 : cur - step[WIDTH-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_meta_d  = enc_a;
    a_sync_d  = a_meta_q;
    b_meta_d  = enc_b;
    b_sync_d  = b_meta_q;
    strobe    = (presc_q == PRESC_LAST);
    presc_d   = strobe ? '0 : presc_q + 1'b1;
    prime_d   = prime_q;
    a_samp_d  = a_samp_q;
    b_samp_d  = b_samp_q;
    a_deb_d   = a_deb_q;
    b_deb_d   = b_deb_q;
    evt_inc_d = '0;
    evt_dec_d = '0;
    a_agree   = ~(a_sync_q ^ a_samp_q);
    b_agree   = ~(b_sync_q ^ b_samp_q);

    if (strobe) begin
      a_samp_d = a_sync_q;
      b_samp_d = b_sync_q;
      a_deb_d  = (a_agree & a_sync_q) | (~a_agree & a_deb_q);
      b_deb_d  = (b_agree & b_sync_q) | (~b_agree & b_deb_q);
      // The first two strobes only settle the debouncers onto reset-release levels.
      if (prime_q != 2'd2) begin
        prime_d = prime_q + 2'd1;
      end else begin
        evt_inc_d = a_deb_d & ~a_deb_q & ~b_deb_q;
        evt_dec_d = a_deb_d & ~a_deb_q &  b_deb_q;
      end
    end

    pwm_cnt_d = ena ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    dbg_d     = '0;
    for (int i = 0; i < NCH; i++) begin
      value_d[i] = value_q[i];
      if (ena && (evt_inc_q[i] || evt_dec_q[i]))
        value_d[i] = next_value(value_q[i], evt_inc_q[i], sat_mode, step_x4);
      duty_d[i] = (pwm_cnt_q == VMAX) ? value_q[i] : duty_q[i];
      pwm_d[i]  = ena && (pwm_cnt_q < duty_q[i]);
      if (int'(dbg_sel) == i) dbg_d = value_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_q  <= '0;
      a_sync_q  <= '0;
      b_meta_q  <= '0;
      b_sync_q  <= '0;
      presc_q   <= '0;
      prime_q   <= '0;
      a_samp_q  <= '0;
      b_samp_q  <= '0;
      a_deb_q   <= '0;
      b_deb_q   <= '0;
      evt_inc_q <= '0;
      evt_dec_q <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
      dbg_q     <= '0;
      // NOTE: these register arrays are reset element by element; they are flops
      // whose contents are visible on outputs, not RAM that could skip reset.
      for (int i = 0; i < NCH; i++) begin
        value_q[i] <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      a_meta_q  <= a_meta_d;
      a_sync_q  <= a_sync_d;
      b_meta_q  <= b_meta_d;
      b_sync_q  <= b_sync_d;
      presc_q   <= presc_d;
      prime_q   <= prime_d;
      a_samp_q  <= a_samp_d;
      b_samp_q  <= b_samp_d;
      a_deb_q   <= a_deb_d;
      b_deb_q   <= b_deb_d;
      evt_inc_q <= evt_inc_d;
      evt_dec_q <= evt_dec_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      dbg_q     <= dbg_d;
      for (int i = 0; i < NCH; i++) begin
        value_q[i] <= value_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign pwm_out = pwm_q;
  assign dbg_val = dbg_q;

endmodule
